// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle control sequencer for the RV32I core.
// Owns pc, the instruction register, the retired-instruction counter and
// the 3-bit state bus that times the branch unit, regfile, ALU and memory.
// One instruction in flight at a time.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/ready/rdata     instruction fetch handshake (address = pc)
//   is_load/is_store/is_ebreak/has_rd  decoded flags (valid from READ on)
//   taken_branch, branch_target        branch unit result (valid in BRANCH)
//   dmem_req/ready           data memory handshake
//   state                    sequencer state (encoding shared with datapath)
//   pc, instr, instret       architectural registers
//   rd_we                    register-file write strobe (WRITEBACK only)
//   halted, trap             stop indicators
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_ebreak,
    input  logic        has_rd,
    input  logic        taken_branch,
    input  logic [31:0] branch_target,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        rd_we,
    output logic [31:0] instret,
    output logic        halted,
    output logic        trap
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_READ      = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_BRANCH    = 3'd4;
    localparam logic [2:0] S_MEM       = 3'd5;
    localparam logic [2:0] S_WRITEBACK = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] tgt_q, tgt_d;
    logic        pc_sel_q, pc_sel_d;
    logic        halted_q, halted_d;
    logic        trap_q, trap_d;

    // A taken branch to a non-word-aligned target is an instruction
    // address misalignment; a not-taken one is harmless.
    logic misaligned;
    assign misaligned = taken_branch && (branch_target[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (imem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = S_READ;
            S_READ:      state_d = S_EXECUTE;
            S_EXECUTE:   state_d = is_ebreak ? S_HALT : S_BRANCH;
            S_BRANCH: begin
                if (misaligned)                state_d = S_HALT;
                else if (is_load || is_store)  state_d = S_MEM;
                else                           state_d = S_WRITEBACK;
            end
            S_MEM:       if (dmem_ready) state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_FETCH;
            default:     state_d = S_HALT;
        endcase
    end

    // Outputs decoded straight from the state register
    always_comb begin
        imem_req = (state_q == S_FETCH);
        dmem_req = (state_q == S_MEM);
        rd_we    = (state_q == S_WRITEBACK) && has_rd;
    end

    // Architectural registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            instret_q <= 32'h0;
            tgt_q     <= 32'h0;
            pc_sel_q  <= 1'b0;
            halted_q  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            tgt_q     <= tgt_d;
            pc_sel_q  <= pc_sel_d;
            halted_q  <= halted_d;
            trap_q    <= trap_d;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        tgt_d     = tgt_q;
        pc_sel_d  = pc_sel_q;
        halted_d  = halted_q;
        trap_d    = trap_q;
        case (state_q)
            S_FETCH: if (imem_ready) instr_d = imem_rdata;
            S_EXECUTE: if (is_ebreak) halted_d = 1'b1;
            S_BRANCH: begin
                // Branch decision is captured here so later states are free
                // to ignore whatever the branch unit drives afterwards.
                pc_sel_d = taken_branch;
                tgt_d    = branch_target;
                if (misaligned) begin
                    trap_d   = 1'b1;
                    halted_d = 1'b1;
                end
            end
            S_WRITEBACK: begin
                pc_d      = pc_sel_q ? tgt_q : pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign pc      = pc_q;
    assign instr   = instr_q;
    assign instret = instret_q;
    assign halted  = halted_q;
    assign trap    = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes each instruction's
// expected retirement (pc, instret, instr, rd_we, cycle count) and a negedge
// monitor pops and compares when the WRITEBACK->FETCH transition occurs.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        is_load = 1'b0, is_store = 1'b0, is_ebreak = 1'b0, has_rd = 1'b0;
    logic        taken_branch = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        dmem_req, dmem_ready = 1'b0;
    logic [2:0]  state;
    logic [31:0] pc, instr, instret;
    logic        rd_we, halted, trap;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak), .has_rd(has_rd),
        .taken_branch(taken_branch), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .state(state), .pc(pc), .instr(instr), .rd_we(rd_we),
        .instret(instret), .halted(halted), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic [31:0] instr;
        logic        we;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] model_pc = RST_PC;
    logic [31:0] model_instret = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Retirement monitor
    int         cyc = 0;
    logic [2:0] prev_st = 3'd0;
    logic       we_seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cyc = 0;
            prev_st = 3'd0;
        end else begin
            cyc++;
            if (state == 3'd6) we_seen = rd_we;
            if (state == 3'd5) chk("dmem_req_held", {31'd0, dmem_req}, 32'd1);
            if (state == 3'd7) chk("halt_quiet", {29'd0, imem_req, dmem_req, rd_we}, 32'd0);
            if (prev_st == 3'd6 && state == 3'd0) begin
                if (sb.size() == 0) chk("retire_unexpected", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("ret_pc", pc, e.pc);
                    chk("ret_instret", instret, e.instret);
                    chk("ret_instr", instr, e.instr);
                    chk("ret_rd_we", {31'd0, we_seen}, {31'd0, e.we});
                    chk("ret_cycles", cyc - 1, e.cyc);
                end
                cyc = 1;
            end
            prev_st = state;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_pc = RST_PC;
        model_instret = 32'h0;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_flags", {30'd0, halted, trap}, 32'd0);
        chk("rst_reqs", {29'd0, imem_req, dmem_req, rd_we}, 32'b100);
        chk("sb_drained", sb.size(), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one instruction starting at a negedge in FETCH. Inputs that
    // should be ignored are driven to misleading values outside their state.
    task automatic do_instr(input logic tk, input logic [31:0] tgt, input logic ld,
                            input logic st, input logic eb, input logic hrd,
                            input int iw, input int dw, input logic [31:0] word,
                            input logic abort);
        logic trap_exp, halt_exp, done;
        logic [2:0] s;
        int n, wi, wd;
        exp_t e;
        trap_exp = !eb && tk && (tgt[1:0] != 2'b00);
        halt_exp = eb || trap_exp;
        e.pc = tk ? tgt : model_pc + 32'd4;
        e.instret = model_instret + 32'd1;
        e.instr = word;
        e.we = hrd;
        e.cyc = 6 + ((ld || st) ? 1 : 0) + iw + dw;
        if (!halt_exp && !abort) sb.push_back(e);
        is_load = ld; is_store = st; is_ebreak = eb; has_rd = hrd;
        n = 0; wi = 0; wd = 0; done = 1'b0;
        while (!done && n < 100) begin
            s = state;
            imem_ready = 1'b1; dmem_ready = 1'b1; imem_rdata = ~word;
            taken_branch = ~tk; branch_target = ~tgt;
            case (s)
                3'd0: begin
                    imem_ready = (wi >= iw);
                    if (wi >= iw) imem_rdata = word;
                    wi++;
                end
                3'd4: begin taken_branch = tk; branch_target = tgt; end
                3'd5: begin dmem_ready = (wd >= dw); wd++; end
                default: ;
            endcase
            if (abort && s == 3'd5) begin
                do_reset();
                done = 1'b1;
            end else if (s == 3'd7) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                n++;
                if (s == 3'd6 && state == 3'd0) done = 1'b1;
            end
        end
        if (!done) chk("drv_timeout", 32'd1, 32'd0);
        if (halt_exp) begin
            chk("halt_latency", n, iw + (eb ? 4 : 5));
            chk("halt_state", {29'd0, state}, 32'd7);
            chk("halt_flags", {30'd0, halted, trap}, {30'd0, 1'b1, trap_exp});
            chk("halt_pc", pc, model_pc);
            chk("halt_instret", instret, model_instret);
        end else if (!abort) begin
            model_pc = e.pc;
            model_instret = e.instret;
        end
    endtask

    task automatic idle_halted();
        repeat (4) begin
            imem_ready = 1'b1; dmem_ready = 1'b1; taken_branch = 1'b1;
            @(negedge clk);
        end
        chk("halt_absorb", {29'd0, state}, 32'd7);
        chk("halt_absorb_pc", pc, model_pc);
    endtask

    initial begin
        do_reset();
        // NOP stream
        repeat (3) do_instr(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0000_0013, 1'b0);
        chk("nop_instret", instret, 32'd3);
        chk("nop_pc", pc, RST_PC + 32'd12);
        // Branches: taken to 0x40, taken 0x40->0x100, back, not-taken misaligned
        do_instr(1'b1, 32'h40,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0400_0063, 1'b0);
        do_instr(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0c00_0063, 1'b0);
        chk("br_taken_pc", pc, 32'h100);
        do_instr(1'b1, 32'h40,  1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'hf41f_f0ef, 1'b0);
        do_instr(1'b0, 32'h103, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0c10_0063, 1'b0);
        chk("br_not_taken_pc", pc, 32'h44);
        chk("br_no_trap", {30'd0, halted, trap}, 32'd0);
        // Load with waits, store zero-wait
        do_instr(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 3, 32'h0000_a103, 1'b0);
        do_instr(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0020_a023, 1'b0);
        // PC wrap through 0xFFFF_FFFC
        do_instr(1'b1, 32'hffff_fffc, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h8000_006f, 1'b0);
        do_instr(1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0463, 1'b0);
        chk("pc_wrap", pc, 32'h0);
        // Taken JAL to misaligned 0x102 traps
        do_instr(1'b1, 32'h102, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h1020_00ef, 1'b0);
        idle_halted();
        // EBREAK
        do_reset();
        do_instr(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0010_0073, 1'b0);
        idle_halted();
        // Reset mid-MEM
        do_reset();
        do_instr(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0000_0013, 1'b0);
        do_instr(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 10, 32'h0000_a183, 1'b1);
        do_instr(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0000_0013, 1'b0);
        chk("post_rst_pc", pc, RST_PC + 32'd4);
        repeat (2) @(negedge clk);
        chk("sb_final", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
